// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry and depth helper.
package regfile_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int NR_DEF = 2;
  localparam int DEPTH_DEF = 1 << AW_DEF;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: combinational word mux, busy lookup and, with REGFILE_BYPASS_EN defined,
// same-cycle forwarding of write-back data (lane 1 over lane 0).
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [DEPTH*DW-1:0] mem_flat,
  input  logic [DEPTH-1:0]    busy_vec,
  input  logic [AW-1:0]       raddr,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [DW-1:0]       wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [DW-1:0]       wdata1,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [DW-1:0]       rdata,
  output logic                busy
);

  logic [DW-1:0] stored;
  logic          stored_busy;

  assign stored      = (raddr == '0) ? '0 : mem_flat[int'(raddr)*DW +: DW];
  assign stored_busy = busy_vec[raddr];

`ifdef REGFILE_BYPASS_EN
  logic hit0, hit1, iss_hit;

  assign hit0    = we0 && (waddr0 == raddr) && (raddr != '0);
  assign hit1    = we1 && (waddr1 == raddr) && (raddr != '0);
  assign iss_hit = iss_en && (iss_addr == raddr);

  always_comb begin
    rdata = stored;
    if (hit1)
      rdata = wdata1;
    else if (hit0)
      rdata = wdata0;
  end

  // A retiring write clears the bit unless a newer instruction claims the register this cycle.
  assign busy = stored_busy && !((hit0 || hit1) && !iss_hit);
`else
  logic unused_bypass;

  assign unused_bypass = ^{we0, waddr0, wdata0, we1, waddr1, wdata1, iss_en, iss_addr};
  assign rdata = stored;
  assign busy  = stored_busy;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write-back lanes and a busy scoreboard; r0 reads zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = NR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WE0,
  input  logic [AW-1:0]    rW0,
  input  logic [DW-1:0]    W0,
  input  logic             WE1,
  input  logic [AW-1:0]    rW1,
  input  logic [DW-1:0]    W1,
  input  logic [NR*AW-1:0] rR,
  output logic [NR*DW-1:0] R,
  output logic [NR-1:0]    busy,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr
);

  localparam int DEPTH = depth_of(AW);

  logic [DEPTH*DW-1:0] mem_flat;
  logic [DEPTH-1:0]    busy_vec;

  assign mem_flat[DW-1:0] = '0;
  assign busy_vec[0]      = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_word
      logic [DW-1:0] word_reg;
      logic          busy_reg;
      logic          hit0, hit1, iss_hit;

      assign hit0    = WE0 && (rW0 == AW'(gi));
      assign hit1    = WE1 && (rW1 == AW'(gi));
      assign iss_hit = iss_en && (iss_addr == AW'(gi));

      // Lane 1 wins a data collision; an issue outranks a retiring clear.
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          if (hit1)
            word_reg <= W1;
          else if (hit0)
            word_reg <= W0;
          if (iss_hit)
            busy_reg <= 1'b1;
          else if (hit0 || hit1)
            busy_reg <= 1'b0;
        end
      end

      assign mem_flat[gi*DW +: DW] = word_reg;
      assign busy_vec[gi]          = busy_reg;
    end

    for (gi = 0; gi < NR; gi++) begin : g_rd
      regfile_rdport #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
      ) u_rdport (
        .mem_flat (mem_flat),
        .busy_vec (busy_vec),
        .raddr    (rR[gi*AW +: AW]),
        .we0      (WE0),
        .waddr0   (rW0),
        .wdata0   (W0),
        .we1      (WE1),
        .waddr1   (rW1),
        .wdata1   (W1),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rdata    (R[gi*DW +: DW]),
        .busy     (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, random traffic against an
// array model, and a 16-bit / 8-word / 4-port parameter sweep instance.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        WE0, WE1, iss_en;
  logic [4:0]  rW0, rW1, iss_addr;
  logic [31:0] W0, W1;
  logic [9:0]  rR;
  logic [63:0] R;
  logic [1:0]  busy;

  logic        s_we0, s_we1, s_iss;
  logic [2:0]  s_rw0, s_rw1, s_ia;
  logic [15:0] s_w0, s_w1;
  logic [11:0] s_rr;
  logic [63:0] s_r;
  logic [3:0]  s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .WE0(WE0), .rW0(rW0), .W0(W0),
    .WE1(WE1), .rW1(rW1), .W1(W1),
    .rR(rR), .R(R), .busy(busy),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  regfile_mp #(.DW(16), .AW(3), .NR(4)) dut_s (
    .clk(clk), .rst(rst),
    .WE0(s_we0), .rW0(s_rw0), .W0(s_w0),
    .WE1(s_we1), .rW1(s_rw1), .W1(s_w1),
    .rR(s_rr), .R(s_r), .busy(s_busy),
    .iss_en(s_iss), .iss_addr(s_ia)
  );

  typedef struct {
    logic        rst;
    logic        we0;
    logic [4:0]  rw0;
    logic [31:0] w0;
    logic        we1;
    logic [4:0]  rw1;
    logic [31:0] w1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mem_m[32];
  bit          busy_m[32];

  task automatic add(input logic rst_i, input logic we0, input logic [4:0] rw0, input logic [31:0] w0,
                     input logic we1, input logic [4:0] rw1, input logic [31:0] w1,
                     input logic iss, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
    vec_t v;
    v.rst = rst_i; v.we0 = we0; v.rw0 = rw0; v.w0 = w0;
    v.we1 = we1; v.rw1 = rw1; v.w1 = w1; v.iss = iss; v.ia = ia;
    v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs settle before the next rising edge.
  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst; WE0 = v.we0; rW0 = v.rw0; W0 = v.w0;
    WE1 = v.we1; rW1 = v.rw1; W1 = v.w1;
    iss_en = v.iss; iss_addr = v.ia;
    rR = {v.ra1, v.ra0};
    #1;
  endtask

  function automatic logic [31:0] model_r(input logic [4:0] a, input vec_t v);
    if (a == 0) return 32'h0;
    if (BYP && v.we1 && v.rw1 == a) return v.w1;
    if (BYP && v.we0 && v.rw0 == a) return v.w0;
    return mem_m[a];
  endfunction

  function automatic logic model_b(input logic [4:0] a, input vec_t v);
    bit wr_hit;
    wr_hit = (v.we0 && v.rw0 == a) || (v.we1 && v.rw1 == a);
    return busy_m[a] && !(BYP && wr_hit && !(v.iss && v.ia == a));
  endfunction

  // State the register file should hold after the coming rising edge.
  task automatic model_step(input vec_t v);
    if (v.rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_m[i] = 32'h0;
        busy_m[i] = 1'b0;
      end
    end else begin
      if (v.we0 && v.rw0 != 0) begin mem_m[v.rw0] = v.w0; busy_m[v.rw0] = 1'b0; end
      if (v.we1 && v.rw1 != 0) begin mem_m[v.rw1] = v.w1; busy_m[v.rw1] = 1'b0; end
      if (v.iss && v.ia != 0) busy_m[v.ia] = 1'b1;
    end
  endtask

  initial begin
    vec_t v;
    logic [15:0] sv[8];

    rst = 1'b1; WE0 = 0; WE1 = 0; rW0 = 0; rW1 = 0; W0 = 0; W1 = 0;
    iss_en = 0; iss_addr = 0; rR = 0;
    s_we0 = 0; s_we1 = 0; s_iss = 0; s_rw0 = 0; s_rw1 = 0; s_ia = 0;
    s_w0 = 0; s_w1 = 0; s_rr = 0;
    for (int i = 0; i < 32; i++) begin mem_m[i] = 0; busy_m[i] = 0; end
    repeat (2) @(posedge clk);

    // rst we0 rw0 w0  we1 rw1 w1  iss ia  ra0 ra1  e0 e1 eb
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 31, 0, 0, 2'b00);
    add(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    add(1, 1, 5, 32'h77, 0, 0, 0, 1, 5, 0, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 2'b00);
    add(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00);
    add(0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 1, BYP ? 32'h22 : 32'h0, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h22, 32'h22, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 3, 0, 0, 2'b00);
    add(0, 1, 3, 32'hAA, 0, 0, 0, 0, 0, 3, 3, BYP ? 32'hAA : 32'h0, BYP ? 32'hAA : 32'h0,
        BYP ? 2'b00 : 2'b11);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 32'hAA, 32'hAA, 2'b00);
    add(0, 0, 0, 0, 1, 4, 32'h55, 1, 4, 4, 3, BYP ? 32'h55 : 32'h0, 32'hAA, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 32'h55, 32'h55, 2'b11);
    add(0, 1, 9, 32'hCAFE, 0, 0, 0, 0, 0, 9, 4, BYP ? 32'hCAFE : 32'h0, 32'h55, 2'b10);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'hCAFE, 32'hCAFE, 2'b00);
    add(0, 0, 0, 0, 1, 4, 32'h66, 0, 0, 4, 9, BYP ? 32'h66 : 32'h55, 32'hCAFE,
        BYP ? 2'b00 : 2'b01);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 32'h66, 32'h66, 2'b00);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check($sformatf("vec%0d_r0", i), R[31:0], vecs[i].e0);
      check($sformatf("vec%0d_r1", i), R[63:32], vecs[i].e1);
      check($sformatf("vec%0d_busy", i), {30'h0, busy}, {30'h0, vecs[i].eb});
      $display("vec %0d rR=%0d,%0d R=%h,%h busy=%b", i, vecs[i].ra0, vecs[i].ra1,
               R[31:0], R[63:32], busy);
      model_step(vecs[i]);
    end

    // Random traffic, biased toward low registers so collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      v.rst = ($urandom_range(0, 49) == 0);
      v.we0 = !v.rst && $urandom_range(0, 1);
      v.we1 = !v.rst && $urandom_range(0, 1);
      v.iss = $urandom_range(0, 2) == 0;
      v.rw0 = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v.rw1 = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v.ia  = 5'($urandom_range(0, 7));
      v.ra0 = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v.ra1 = 5'($urandom_range(0, 7));
      v.w0  = $urandom;
      v.w1  = $urandom;
      drive(v);
      check($sformatf("rnd%0d_r0", n), R[31:0], model_r(v.ra0, v));
      check($sformatf("rnd%0d_r1", n), R[63:32], model_r(v.ra1, v));
      check($sformatf("rnd%0d_busy", n), {30'h0, busy}, {30'h0, model_b(v.ra1, v), model_b(v.ra0, v)});
      model_step(v);
    end

    // Parameter sweep: DW=16, AW=3, NR=4.
    @(negedge clk);
    rst = 1'b0; WE0 = 0; WE1 = 0; iss_en = 0;
    for (int i = 0; i < 8; i++) sv[i] = (i == 0) ? 16'h0 : 16'hA000 + 16'(i) * 16'h0101;
    for (int i = 1; i <= 4; i++) begin
      s_we0 = 1'b1; s_rw0 = 3'(2 * i - 1); s_w0 = sv[2 * i - 1];
      s_we1 = (2 * i <= 7); s_rw1 = 3'(2 * i); s_w1 = (2 * i <= 7) ? sv[2 * i] : 16'h0;
      @(negedge clk);
    end
    s_we0 = 0; s_we1 = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) s_rr[k*3 +: 3] = 3'((4 * p + k + 1) % 8);
      #1;
      for (int k = 0; k < 4; k++)
        check($sformatf("sweep_p%0d_port%0d", p, k), {16'h0, s_r[k*16 +: 16]},
              {16'h0, sv[(4 * p + k + 1) % 8]});
      check($sformatf("sweep_p%0d_busy", p), {28'h0, s_busy}, 32'h0);
      $display("sweep %0d R=%h busy=%b", p, s_r, s_busy);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined CPU datapath. It provides 2^AW words of DW bits, NR combinational read ports and two write-back ports. A per-register busy scoreboard lets decode stall on pending writes. Register 0 is hard-wired to zero. The block sits between decode (reads, issue) and write-back (two retire lanes).

## Interface
Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2^AW.
- NR, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- WE0  in  1  write enable, lane 0.
- rW0  in  AW  write address, lane 0.
- W0  in  DW  write data, lane 0.
- WE1  in  1  write enable, lane 1.
- rW1  in  AW  write address, lane 1.
- W1  in  DW  write data, lane 1.
- rR  in  NR*AW  flattened read addresses; port k = bits [k*AW +: AW].
- R  out  NR*DW  flattened read data; port k = bits [k*DW +: DW].
- busy  out  NR  busy bit of each read port's register.
- iss_en  in  1  issue strobe; marks iss_addr busy.
- iss_addr  in  AW  destination register being issued.

## Operation
- Storage: 2^AW × DW flops plus a 2^AW-bit busy vector.
- Reset (rst=1 at posedge): all words go to 0 and all busy bits go to 0. Reset has priority over every write and issue in that cycle.
- Writes: WEn=1 with rWn≠0 stores Wn at posedge. Writes to address 0 are discarded.
- Both lanes writing the same nonzero address: lane 1 wins, lane 0 data is dropped.
- Reads are combinational: R[k] = mem[rR[k]], and R[k] = 0 whenever rR[k]=0.
- Scoreboard:
  - Issue (iss_en=1, iss_addr≠0) sets busy[iss_addr].
  - A write on either lane clears busy[rWn].
  - Issue and write to the same address in the same cycle: issue wins and busy stays 1, because the newer instruction owns the register.
  - Issue to address 0 is ignored; busy[0] is always 0.
- busy[k] reflects the registered busy bit of rR[k]. It is combinational from rR, with no same-cycle forwarding of issue or clear.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible on R from edge N onward.
- Read latency: 0 cycles (combinational, address to data).
- busy sets or clears at the edge following iss_en or WEn.
- Outputs after reset: R = 0 for every address, busy = 0.
- Reset asserted mid-stream: the cycle's writes and issues are discarded, and state is zero on the next cycle.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose rR[k] matches an active write address (nonzero) returns that write data in the same cycle. The lane 1 match has priority over lane 0. The busy output for that port reads 0 when the matching write is clearing it and there is no same-address issue.
- REGFILE_BYPASS_EN undefined: reads return only stored contents, so old data is seen during the write cycle. busy is purely registered.

## Structure
- The shared package (regfile_pkg) holds the default DW/AW/NR constants and the width localparams (DEPTH = 1<<AW).
- One sub-module, regfile_rdport: one read mux plus optional bypass plus busy lookup, instantiated NR times in a generate loop.
- Storage, the write-priority logic and the scoreboard stay in the top module.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert rst for 1 cycle → R(r5)=0 and all busy=0 on the next cycle.
- Zero register: WE0=1, rW0=0, W0=0x1234; read r0 → 0.
- Dual-lane collision: WE0 writes r7=0x11 and WE1 writes r7=0x22 in the same cycle → r7=0x22 afterwards.
- Scoreboard: issue r3 → busy=1 next cycle; then write r3 → busy=0. Issue and write r4 in the same cycle → busy[r4]=1.
- Bypass (REGFILE_BYPASS_EN): write r9=0xCAFE while reading r9 in that cycle → R=0xCAFE. Without the macro → R=old value (0), and 0xCAFE appears the next cycle.
- Parameter sweep with DW=16, AW=3, NR=4: write distinct values to r1..r7 and read all four ports simultaneously → each port returns its own value.
